// File: rtl/fiat_25519_carry_square_mul_arbiter_if.sv
// Bundle of request, shared-multiplier and result signals around the carry_square mul arbiter.
// The slave view belongs to the arbiter; the master view belongs to its surroundings.
interface fiat_25519_carry_square_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 33,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic [DIN0_WIDTH-1:0]         mul_din0;
  logic [DIN1_WIDTH-1:0]         mul_din1;
  logic [DOUT_WIDTH-1:0]         mul_dout;
  logic                          out_valid;
  logic                          out_ready;
  logic [DOUT_WIDTH-1:0]         out_dout;
  logic [ID_WIDTH-1:0]           out_id;

  modport slave (
    input  req_valid, req_din0, req_din1, mul_dout, out_ready,
    output req_ready, mul_din0, mul_din1, out_valid, out_dout, out_id
  );

  modport master (
    output req_valid, req_din0, req_din1, mul_dout, out_ready,
    input  req_ready, mul_din0, mul_din1, out_valid, out_dout, out_id
  );
endinterface

// File: rtl/fiat_25519_carry_square_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 33x32 multiplier among NUM_REQ limb-product
// requesters; operand register -> product register pipeline with valid/ready result and id tag.
module fiat_25519_carry_square_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 33,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 64
) (
  input logic                                  ap_clk,
  input logic                                  ap_rst_n,
  fiat_25519_carry_square_mul_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  s1_valid_q, s1_valid_d;
  logic [DIN0_WIDTH-1:0] s1_din0_q,  s1_din0_d;
  logic [DIN1_WIDTH-1:0] s1_din1_q,  s1_din1_d;
  logic [ID_WIDTH-1:0]   s1_id_q,    s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DOUT_WIDTH-1:0] s2_dout_q,  s2_dout_d;
  logic [ID_WIDTH-1:0]   s2_id_q,    s2_id_d;
  logic [PTR_W-1:0]      rr_ptr_q,   rr_ptr_d;

  logic                  s2_adv;
  logic                  s1_adv;
  logic                  req_hit;
  logic                  grant_any;
  logic [PTR_W-1:0]      scan_idx;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [DIN0_WIDTH-1:0] sel_din0;
  logic [DIN1_WIDTH-1:0] sel_din1;

  assign s2_adv = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign s1_adv = ~s1_valid_q | s2_adv;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    req_hit   = 1'b0;
    scan_idx  = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!req_hit && bus.req_valid[scan_idx]) begin
        req_hit   = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign grant_any     = req_hit & s1_adv & ap_rst_n;
  assign grant         = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.req_ready = grant;

  always_comb begin
    sel_din0 = '0;
    sel_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_din0 = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_din1 = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  always_comb begin
    // S1: operand register feeding the shared multiplier
    s1_valid_d = s1_valid_q;
    s1_din0_d  = s1_din0_q;
    s1_din1_d  = s1_din1_q;
    s1_id_d    = s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_any) begin
      s1_valid_d = 1'b1;
      s1_din0_d  = sel_din0;
      s1_din1_d  = sel_din1;
      s1_id_d    = ID_WIDTH'(grant_idx);
      rr_ptr_d   = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2: product register; data is left in place when drained so the output stays stable
    s2_valid_d = s2_valid_q;
    s2_dout_d  = s2_dout_q;
    s2_id_d    = s2_id_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_dout_d  = bus.mul_dout;
      s2_id_d    = s1_id_q;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_din0_q  <= '0;
      s1_din1_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_dout_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_din0_q  <= s1_din0_d;
      s1_din1_q  <= s1_din1_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_dout_q  <= s2_dout_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.mul_din0  = s1_din0_q;
  assign bus.mul_din1  = s1_din1_q;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_dout  = s2_dout_q;
  assign bus.out_id    = s2_id_q;

endmodule

// File: tb/tb_fiat_25519_carry_square_mul_arbiter.sv
// Directed bench for the carry_square multiplier arbiter with a behavioural shared multiplier.
module tb_fiat_25519_carry_square_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ID_WIDTH   = 2;
  localparam int DIN0_WIDTH = 33;
  localparam int DIN1_WIDTH = 32;
  localparam int DOUT_WIDTH = 64;

  logic ap_clk;
  logic ap_rst_n;
  int   n_cmp;
  int   n_fail;

  fiat_25519_carry_square_mul_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
  ) bus ();

  fiat_25519_carry_square_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  // Shared combinational multiplier, low 64 bits of the product
  assign bus.mul_dout = {31'b0, bus.mul_din0} * {32'b0, bus.mul_din1};

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [32:0] a, input logic [31:0] b);
    bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH] = a;
    bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH] = b;
  endtask

  task automatic do_reset();
    ap_rst_n      = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    ap_rst_n      = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.out_ready = 1'b1;
    set_req(0, 33'd9, 32'd9);

    // Reset state, with a request pending to show req_ready is held low
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_dout",  bus.out_dout,       64'd0);
    chk("rst_out_id",    64'(bus.out_id),    64'd0);
    chk("rst_mul_din0",  64'(bus.mul_din0),  64'd0);
    chk("rst_mul_din1",  64'(bus.mul_din1),  64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    ap_rst_n = 1'b1;
    tick();

    // T1 single request
    set_req(0, 33'd3, 32'd5);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    chk("t1_valid_t1", 64'(bus.out_valid), 64'd0);
    chk("t1_mul_din0", 64'(bus.mul_din0),  64'd3);
    chk("t1_mul_din1", 64'(bus.mul_din1),  64'd5);
    tick();
    chk("t1_valid_t2", 64'(bus.out_valid), 64'd1);
    chk("t1_dout",     bus.out_dout,       64'hF);
    chk("t1_id",       64'(bus.out_id),    64'd0);
    tick();
    chk("t1_drained",  64'(bus.out_valid), 64'd0);
    chk("t1_dout_kept", bus.out_dout,      64'hF);

    // T2 all requesters once, from rr_ptr=0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 33'(i + 1), 32'd1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 4) chk($sformatf("t2_ready_%0d", k), 64'(bus.req_ready), 64'(4'b0001 << k));
      if (k >= 2) begin
        chk($sformatf("t2_valid_%0d", k), 64'(bus.out_valid), 64'd1);
        chk($sformatf("t2_id_%0d", k),    64'(bus.out_id),    64'(k - 2));
        chk($sformatf("t2_dout_%0d", k),  bus.out_dout,       64'(k - 1));
      end
      tick();
      if (k < 4) bus.req_valid = bus.req_valid & ~(4'b0001 << k);
    end
    chk("t2_idle", 64'(bus.out_valid), 64'd0);
    bus.req_valid = 4'b1001;
    #1;
    chk("t2_ptr_wrapped", 64'(bus.req_ready), 64'h1);
    bus.req_valid = '0;

    // T3 backpressure with requesters 1..3 pending
    for (int i = 1; i < NUM_REQ; i++) set_req(i, 33'(10 + i), 32'd2);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1110;
    #1;
    chk("t3_ready_a", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 4'b1100;
    #1;
    chk("t3_ready_b", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t3_stall_ready_%0d", c), 64'(bus.req_ready), 64'd0);
      chk($sformatf("t3_stall_valid_%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("t3_stall_dout_%0d", c),  bus.out_dout,       64'd22);
      chk($sformatf("t3_stall_id_%0d", c),    64'(bus.out_id),    64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_ready_c", 64'(bus.req_ready), 64'h8);
    tick();
    bus.req_valid = '0;
    chk("t3_out2_dout", bus.out_dout,    64'd24);
    chk("t3_out2_id",   64'(bus.out_id), 64'd2);
    tick();
    chk("t3_out3_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_out3_dout",  bus.out_dout,       64'd26);
    chk("t3_out3_id",    64'(bus.out_id),    64'd3);
    tick();
    chk("t3_no_dup", 64'(bus.out_valid), 64'd0);

    // T4 maximum operands, product truncated to 64 bits
    set_req(0, 33'h1_FFFF_FFFF, 32'hFFFF_FFFF);
    bus.req_valid = 4'b0001;
    #1;
    chk("t4_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    tick();
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_dout",  bus.out_dout,       64'hFFFF_FFFD_0000_0001);
    tick();

    // T5 fairness: req0 held valid, req2 arrives once
    set_req(0, 33'd7, 32'd1);
    set_req(2, 33'd9, 32'd1);
    bus.req_valid = 4'b0001;
    #1;
    chk("t5_g0", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 4'b0101;
    #1;
    chk("t5_g2", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = 4'b0001;
    #1;
    chk("t5_g0b",     64'(bus.req_ready), 64'h1);
    chk("t5_out0_id", 64'(bus.out_id),    64'd0);
    chk("t5_out0",    bus.out_dout,       64'd7);
    tick();
    bus.req_valid = '0;
    chk("t5_out2_id", 64'(bus.out_id), 64'd2);
    chk("t5_out2",    bus.out_dout,    64'd9);
    tick();
    chk("t5_out0b_id", 64'(bus.out_id), 64'd0);
    chk("t5_out0b",    bus.out_dout,    64'd7);
    tick();
    chk("t5_idle", 64'(bus.out_valid), 64'd0);

    // T6 reset with both stages full
    set_req(1, 33'd5, 32'd5);
    set_req(2, 33'd6, 32'd6);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0110;
    tick();
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    chk("t6_full_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_full_dout",  bus.out_dout,       64'd25);
    ap_rst_n = 1'b0;
    bus.req_valid = 4'b1000;
    tick();
    chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_dout",  bus.out_dout,       64'd0);
    chk("t6_rst_id",    64'(bus.out_id),    64'd0);
    chk("t6_rst_din0",  64'(bus.mul_din0),  64'd0);
    bus.req_valid = '0;
    ap_rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("t6_after_a", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t6_after_b", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t6_after_c", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
